// File: rtl/pe_conv_ctrl.sv
// Sequencer for a 3-tap MAC PE computing a 3x3 valid convolution (stride 1) over an SRAM image.
// Output rows are accumulated over three kernel-row passes, then streamed over valid/ready.
module pe_conv_ctrl #(
    parameter int unsigned DATA_BITS     = 16,
    parameter int unsigned INTERNAL_BITS = 32,
    parameter int unsigned ADDR_BITS     = 16,
    parameter int unsigned IMG_W         = 8,
    parameter int unsigned IMG_H         = 8,
    parameter int unsigned W_BASE        = 0,
    parameter int unsigned IF_BASE       = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     mem_rd,
    output logic [ADDR_BITS-1:0]     mem_addr,
    input  logic [DATA_BITS-1:0]     mem_rdata,
    output logic                     pe_W_w,
    output logic                     pe_IF_w,
    output logic [DATA_BITS-1:0]     pe_W_in,
    output logic [DATA_BITS-1:0]     pe_IF_in,
    input  logic [INTERNAL_BITS-1:0] pe_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INTERNAL_BITS-1:0] out_data
);

    localparam int unsigned CW = $clog2(IMG_W + 2);
    localparam int unsigned NC = IMG_W - 2;
    localparam int unsigned IW = (NC > 1) ? $clog2(NC) : 1;
    localparam int unsigned RW = $clog2(IMG_H);

    typedef enum logic [1:0] {StIdle, StLdw, StLdf, StDrain} state_t;

    state_t                   state;
    logic [CW-1:0]            cnt;
    logic [CW-1:0]            n;
    logic [CW-1:0]            d;
    logic [1:0]               k;
    logic [RW-1:0]            r;
    logic                     cap_valid;
    logic [IW-1:0]            cap_col;
    logic [INTERNAL_BITS-1:0] cap_sum;
    logic [INTERNAL_BITS-1:0] psum [NC];

    function automatic logic [ADDR_BITS-1:0] w_addr(input logic [1:0] kk);
        return ADDR_BITS'(W_BASE + 3 * int'(kk));
    endfunction

    function automatic logic [ADDR_BITS-1:0] if_addr(input logic [RW-1:0] rr, input logic [1:0] kk);
        return ADDR_BITS'(IF_BASE + (int'(rr) + int'(kk)) * IMG_W);
    endfunction

    assign pe_W_in  = mem_rdata;
    assign pe_IF_in = mem_rdata;

    // First kernel row starts the accumulation from zero instead of the previous row's leftovers.
    assign cap_sum = ((k == 2'd0) ? '0 : psum[cap_col]) + pe_result;

    always_ff @(posedge clk) begin
        if (cap_valid) psum[cap_col] <= cap_sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
            pe_W_w    <= 1'b0;
            pe_IF_w   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            cnt       <= '0;
            n         <= '0;
            d         <= '0;
            k         <= '0;
            r         <= '0;
            cap_valid <= 1'b0;
            cap_col   <= '0;
        end else begin
            done      <= 1'b0;
            pe_W_w    <= mem_rd && (state == StLdw);
            pe_IF_w   <= mem_rd && (state == StLdf);
            cap_valid <= 1'b0;
            // A column is complete once three pixels of this pass sit in the PE.
            if (pe_IF_w) begin
                n <= n + CW'(1);
                if (n >= CW'(2)) begin
                    cap_valid <= 1'b1;
                    cap_col   <= IW'(n - CW'(2));
                end
            end
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state    <= StLdw;
                        busy     <= 1'b1;
                        r        <= '0;
                        k        <= '0;
                        cnt      <= '0;
                        mem_rd   <= 1'b1;
                        mem_addr <= w_addr(2'd0);
                    end
                end
                StLdw: begin
                    n <= '0;
                    if (cnt == CW'(2)) begin
                        state    <= StLdf;
                        cnt      <= '0;
                        mem_addr <= if_addr(r, k);
                    end else begin
                        cnt      <= cnt + CW'(1);
                        mem_addr <= mem_addr + ADDR_BITS'(1);
                    end
                end
                StLdf: begin
                    cnt <= cnt + CW'(1);
                    if (cnt < CW'(IMG_W - 1)) begin
                        mem_addr <= mem_addr + ADDR_BITS'(1);
                    end else if (cnt == CW'(IMG_W - 1)) begin
                        mem_rd <= 1'b0;
                    end
                    // Last capture cycle of the pass.
                    if (cnt == CW'(IMG_W + 1)) begin
                        cnt <= '0;
                        if (k != 2'd2) begin
                            k        <= k + 2'd1;
                            state    <= StLdw;
                            mem_rd   <= 1'b1;
                            mem_addr <= w_addr(k + 2'd1);
                        end else begin
                            state     <= StDrain;
                            d         <= '0;
                            out_valid <= 1'b1;
                            out_data  <= (NC == 1) ? cap_sum : psum[0];
                        end
                    end
                end
                StDrain: begin
                    if (out_ready) begin
                        if (d == CW'(NC - 1)) begin
                            out_valid <= 1'b0;
                            if (r != RW'(IMG_H - 3)) begin
                                r        <= r + RW'(1);
                                k        <= '0;
                                state    <= StLdw;
                                mem_rd   <= 1'b1;
                                mem_addr <= w_addr(2'd0);
                            end else begin
                                state <= StIdle;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else begin
                            d        <= d + CW'(1);
                            out_data <= psum[IW'(d + CW'(1))];
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_conv_ctrl.sv
// Scoreboard bench for pe_conv_ctrl: SRAM and 3-tap PE models, expected outputs from direct
// convolution arithmetic, popped by an independent monitor on every output handshake.
module tb_pe_conv_ctrl;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int WB = 0;
    localparam int IB = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, mem_rd, pe_W_w, pe_IF_w, out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] mem_addr, mem_rdata, pe_W_in, pe_IF_in;
    logic [31:0] pe_result, out_data;

    pe_conv_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .pe_W_w    (pe_W_w),
        .pe_IF_w   (pe_IF_w),
        .pe_W_in   (pe_W_in),
        .pe_IF_in  (pe_IF_in),
        .pe_result (pe_result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    logic [15:0]        mem [256];
    logic signed [15:0] pw [3];
    logic signed [15:0] pf [3];

    always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr[7:0]];

    // Index 2 is the oldest slot of each shift chain.
    always @(posedge clk) begin
        if (pe_W_w) begin
            pw[2] <= pw[1]; pw[1] <= pw[0]; pw[0] <= pe_W_in;
        end
        if (pe_IF_w) begin
            pf[2] <= pf[1]; pf[1] <= pf[0]; pf[0] <= pe_IF_in;
        end
    end

    always_comb begin
        pe_result = 32'(int'(pw[0]) * int'(pf[0]) + int'(pw[1]) * int'(pf[1])
                        + int'(pw[2]) * int'(pf[2]));
    end

    int  wt [9];
    int  px [H*W];
    int  exp_q [$];
    int  checks = 0, errors = 0;
    int  cyc = 0, last_hs = -10, hs_cnt = 0, done_cnt = 0;
    int  overlap = 0, drain_rd = 0, stall_bad = 0;
    bit  rand_ready = 1'b0;
    bit  stall_prev = 1'b0;
    logic [31:0] prev_data = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1 out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: scoreboard pops, done timing, and protocol invariants.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("extra_output", 32'd1, 32'd0);
                else check("out_data", out_data, exp_q.pop_front());
                last_hs = cyc;
                hs_cnt++;
            end
            if (done) begin
                done_cnt++;
                check("done_after_last_hs", cyc - last_hs, 32'd1);
                check("done_queue_empty", exp_q.size(), 32'd0);
            end
            if (pe_W_w && pe_IF_w) overlap++;
            if (out_valid && mem_rd) drain_rd++;
            if (stall_prev && (!out_valid || out_data !== prev_data)) stall_bad++;
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic load_and_expect();
        for (int i = 0; i < 9; i++) mem[WB+i] = wt[i][15:0];
        for (int i = 0; i < H*W; i++) mem[IB+i] = px[i][15:0];
        for (int r = 0; r < H-2; r++)
            for (int c = 0; c < W-2; c++) begin
                int s = 0;
                for (int kr = 0; kr < 3; kr++)
                    for (int kc = 0; kc < 3; kc++)
                        s += wt[3*kr+kc] * px[(r+kr)*W + c+kc];
                exp_q.push_back(s);
            end
    endtask

    task automatic start_layer(input bit chk_reads);
        int nw = 0, nf = 0;
        check("idle_before_start", busy, 32'd0);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check("busy_cycle1", busy, 32'd1);
        check("first_rd_cycle1", mem_rd, 32'd1);
        if (chk_reads) begin
            for (int i = 0; i < 14; i++) begin
                int ea;
                if (i > 0) @(negedge clk);
                ea = (i < 3) ? WB + i : (i < 11) ? IB + i - 3 : WB + 3;
                check("rd_strobe_seq", mem_rd, (i < 11 || i == 13) ? 32'd1 : 32'd0);
                if (i < 11 || i == 13) check("rd_addr_seq", mem_addr, ea);
                nw += int'(pe_W_w);
                nf += int'(pe_IF_w);
            end
            check("pass_w_shifts", nw, 32'd3);
            check("pass_if_shifts", nf, 32'd8);
        end else begin
            check("first_rd_addr", mem_addr, WB);
        end
    endtask

    task automatic wait_done(input int d0);
        int t = 0;
        while (done_cnt == d0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (done_cnt == d0) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            repeat (3) @(negedge clk);
            check("done_once", done_cnt - d0, 32'd1);
            check("busy_after_done", busy, 32'd0);
            check("all_outputs_seen", exp_q.size(), 32'd0);
        end
    endtask

    task automatic run_layer(input bit chk_reads);
        int d0 = done_cnt;
        load_and_expect();
        start_layer(chk_reads);
        wait_done(d0);
    endtask

    task automatic set_ones();
        for (int i = 0; i < 9; i++) wt[i] = 1;
        for (int i = 0; i < H*W; i++) px[i] = 1;
    endtask

    task automatic set_center_ramp();
        for (int i = 0; i < 9; i++) wt[i] = (i == 4) ? 1 : 0;
        for (int i = 0; i < H*W; i++) px[i] = i;
    endtask

    task automatic set_random();
        logic signed [15:0] v;
        for (int i = 0; i < 9; i++) begin v = 16'($urandom); wt[i] = v; end
        for (int i = 0; i < H*W; i++) begin v = 16'($urandom); px[i] = v; end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 32'd0);
        check({tag, "_done"}, done, 32'd0);
        check({tag, "_mem_rd"}, mem_rd, 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_pe_W_w"}, pe_W_w, 32'd0);
        check({tag, "_pe_IF_w"}, pe_IF_w, 32'd0);
        check({tag, "_out_valid"}, out_valid, 32'd0);
        check({tag, "_out_data"}, out_data, 32'd0);
    endtask

    initial begin
        int d0, base, t;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(negedge clk);

        set_ones();        run_layer(1'b1);
        set_center_ramp(); run_layer(1'b0);
        for (int i = 0; i < 9; i++) wt[i] = -1;
        for (int i = 0; i < H*W; i++) px[i] = 100;
        run_layer(1'b0);
        rand_ready = 1'b1;
        set_center_ramp(); run_layer(1'b0);
        set_random();      run_layer(1'b0);
        rand_ready = 1'b0;
        set_random();      run_layer(1'b1);

        // Reset in the middle of output row 2's feature load.
        set_ones();
        d0 = done_cnt;
        load_and_expect();
        start_layer(1'b0);
        base = hs_cnt;
        t = 0;
        while (hs_cnt < base + 12 && t < 3000) begin @(negedge clk); t++; end
        while (!(mem_rd && mem_addr >= 16'(IB)) && t < 3000) begin @(negedge clk); t++; end
        check("reached_row2_ldf", (t < 3000) ? 32'd1 : 32'd0, 32'd1);
        @(negedge clk);
        #1 rst = 1'b1;
        #1 check_all_zero("midrst");
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        check("no_done_on_reset", done_cnt - d0, 32'd0);
        check_all_zero("post_rst");

        // Fresh layer, with a start pulse that must be ignored while busy.
        d0 = done_cnt;
        load_and_expect();
        start_layer(1'b0);
        repeat (40) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(d0);

        check("no_ww_if_overlap", overlap, 32'd0);
        check("no_rd_in_drain", drain_rd, 32'd0);
        check("stall_hold_stable", stall_bad, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
